// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: RX/TX byte FIFOs, sticky overflow flags, irq
// and a sequencer that feeds queued TX bytes to the TX engine one frame at a time.
//
// state     | meaning
// IDLE      | no frame owned; start one as soon as a byte is queued and the engine is free
// WAIT_BUSY | tx_start issued, waiting for the engine to raise tx_busy
// WAIT_DONE | frame in flight; on completion start the next queued byte or go IDLE
module uart_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic        irq
);

   localparam int CW = FIFO_AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [7:0]         rx_mem [FIFO_DEPTH];
   logic [7:0]         tx_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
   logic [CW-1:0]      rx_cnt, tx_cnt;
   logic               rx_ovf, tx_ovf;
   logic [1:0]         ctrl;

   logic [1:0]  reg_sel;
   logic        rd_acc, wr_acc;
   logic        rx_nonempty, rx_full, tx_empty, tx_full, tx_active;
   logic        rx_pop, rx_push, rx_ovf_set;
   logic        tx_req, tx_push, tx_pop, tx_ovf_set;
   logic        sts_wr, ctrl_wr;
   logic [31:0] status_word, count_word, rd_word;
   logic        unused_bits;

   assign reg_sel = addr[3:2];
   assign rd_acc  = sel & ~we;
   assign wr_acc  = sel & we;

   assign rx_nonempty = (rx_cnt != '0);
   assign rx_full     = (rx_cnt == FULL_CNT);
   assign tx_empty    = (tx_cnt == '0);
   assign tx_full     = (tx_cnt == FULL_CNT);
   assign tx_active   = (state != IDLE) | tx_busy;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is not an overflow.
   assign rx_pop     = rd_acc & (reg_sel == 2'd0) & rx_nonempty;
   assign rx_push    = rx_valid & (~rx_full | rx_pop);
   assign rx_ovf_set = rx_valid & rx_full & ~rx_pop;

   assign tx_req     = wr_acc & (reg_sel == 2'd0);
   assign tx_push    = tx_req & (~tx_full | tx_pop);
   assign tx_ovf_set = tx_req & tx_full & ~tx_pop;

   assign sts_wr  = wr_acc & (reg_sel == 2'd1);
   assign ctrl_wr = wr_acc & (reg_sel == 2'd2);

   assign unused_bits = ^{wdata[31:8], addr[1:0]};

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= rx_data;
      if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
         tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      end
   end

   // Setting beats clearing when both land in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_ovf <= 1'b0;
         tx_ovf <= 1'b0;
         ctrl   <= 2'b00;
      end else begin
         rx_ovf <= rx_ovf_set | (rx_ovf & ~(sts_wr & wdata[4]));
         tx_ovf <= tx_ovf_set | (tx_ovf & ~(sts_wr & wdata[5]));
         if (ctrl_wr) ctrl <= wdata[1:0];
      end
   end

   always_comb begin
      status_word = {25'b0, tx_active, tx_ovf, rx_ovf, tx_full, tx_empty, rx_full, rx_nonempty};
      count_word  = '0;
      count_word[FIFO_AW:0]       = rx_cnt;
      count_word[16+FIFO_AW:16]   = tx_cnt;
      rd_word = '0;
      case (reg_sel)
         2'd0:    rd_word = rx_nonempty ? {24'b0, rx_mem[rx_rp]} : 32'b0;
         2'd1:    rd_word = status_word;
         2'd2:    rd_word = {30'b0, ctrl};
         default: rd_word = count_word;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
         ready <= 1'b0;
      end else begin
         ready <= sel;
         if (rd_acc) rdata <= rd_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!tx_empty && !tx_busy) state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
         WAIT_DONE: if (!tx_busy) state_nxt = tx_empty ? IDLE : WAIT_BUSY;
         default:   state_nxt = IDLE;
      endcase
   end

   // Popping straight out of WAIT_DONE lets the next frame start one cycle after tx_busy falls.
   always_comb begin
      tx_pop = 1'b0;
      case (state)
         IDLE, WAIT_DONE: tx_pop = ~tx_empty & ~tx_busy;
         default:         tx_pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_start <= 1'b0;
         tx_data  <= '0;
         irq      <= 1'b0;
      end else begin
         tx_start <= tx_pop;
         if (tx_pop) tx_data <= tx_mem[tx_rp];
         irq <= (ctrl[0] & rx_nonempty) |
                (ctrl[1] & tx_empty & (state == IDLE) & ~tx_busy);
      end
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: queue-based RX model, bench-side TX engine, scenario tasks
// run in sequence from one initial block.
module tb_uart_ctrl;

   localparam int D = 4;

   logic        clk;
   logic        rst;
   logic        sel;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        irq;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] rx_q[$];
   logic       m_rx_ovf, m_tx_ovf;

   logic [7:0] tx_log[$];
   int         start_q[$];
   int         fall_q[$];
   bit         eng_pend;
   int         eng_cnt;

   uart_ctrl #(.FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock step; the TX engine model raises tx_busy one cycle after
   // seeing tx_start and holds it for 20 cycles.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            tx_busy = 1'b0;
            fall_q.push_back(cyc);
         end
      end
      if (eng_pend) begin
         eng_pend = 1'b0;
         tx_busy  = 1'b1;
         eng_cnt  = 20;
      end
      if (tx_start === 1'b1) begin
         tx_log.push_back(tx_data);
         start_q.push_back(cyc);
         eng_pend = 1'b1;
      end
   endtask

   task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic rdy);
      sel = 1'b1; we = w; addr = a; wdata = d;
      step();
      rd  = rdata;
      rdy = ready;
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_valid = 1'b1; rx_data = b;
      step();
      rx_valid = 1'b0;
      if (rx_q.size() < D) rx_q.push_back(b);
      else m_rx_ovf = 1'b1;
   endtask

   task automatic mdl_reset();
      rx_q.delete();
      m_rx_ovf = 1'b0;
      m_tx_ovf = 1'b0;
   endtask

   task automatic clear_logs();
      tx_log.delete();
      start_q.delete();
      fall_q.delete();
   endtask

   function automatic logic [31:0] mdl_status(input int tx_n, input bit active);
      logic [31:0] s;
      s = 32'h0;
      s[0] = (rx_q.size() != 0);
      s[1] = (rx_q.size() == D);
      s[2] = (tx_n == 0);
      s[3] = (tx_n == D);
      s[4] = m_rx_ovf;
      s[5] = m_tx_ovf;
      s[6] = active;
      return s;
   endfunction

   function automatic logic [7:0] mdl_rx_read();
      if (rx_q.size() == 0) return 8'h00;
      return rx_q.pop_front();
   endfunction

   task automatic test_reset();
      logic [31:0] rd;
      logic        rdy;
      rst = 1'b0;
      step(); step();
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready); end
      checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      checks++; if (tx_data !== 8'h0) begin failures++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
      rst = 1'b1;
      mdl_reset();
      step();
      bus(1'b0, 4'h4, 32'h0, rd, rdy);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_ready_pulse: got %b want 1", rdy); end
      checks++; if (rd !== mdl_status(0, 0)) begin failures++; $display("FAIL reset_status: got %h want %h", rd, mdl_status(0, 0)); end
      step();
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ready_one_cycle: got %b want 0", ready); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq_after: got %b want 0", irq); end
   endtask

   task automatic test_rx_basic();
      logic [31:0] rd;
      logic        rdy;
      logic [31:0] exp;
      rx_push(8'h41);
      rx_push(8'h42);
      for (int i = 0; i < 3; i++) begin
         bus(1'b0, 4'h0, 32'h0, rd, rdy);
         exp = {24'h0, mdl_rx_read()};
         checks++; if (rd !== exp) begin failures++; $display("FAIL rx_basic_read%0d: got %h want %h", i, rd, exp); end
      end
      bus(1'b0, 4'h4, 32'h0, rd, rdy);
      checks++; if (rd !== mdl_status(0, 0)) begin failures++; $display("FAIL rx_basic_status: got %h want %h", rd, mdl_status(0, 0)); end
   endtask

   task automatic test_rx_overflow();
      logic [31:0] rd;
      logic        rdy;
      logic [31:0] exp;
      for (int i = 0; i < D + 1; i++) rx_push(8'($urandom));
      bus(1'b0, 4'h4, 32'h0, rd, rdy);
      checks++; if (rd !== mdl_status(0, 0)) begin failures++; $display("FAIL rx_ovf_status: got %h want %h", rd, mdl_status(0, 0)); end
      bus(1'b1, 4'h4, 32'h10, rd, rdy);
      m_rx_ovf = 1'b0;
      bus(1'b0, 4'h4, 32'h0, rd, rdy);
      checks++; if (rd !== mdl_status(0, 0)) begin failures++; $display("FAIL rx_ovf_clear: got %h want %h", rd, mdl_status(0, 0)); end
      bus(1'b0, 4'hC, 32'h0, rd, rdy);
      checks++; if (rd !== 32'(rx_q.size())) begin failures++; $display("FAIL rx_ovf_count: got %h want %h", rd, rx_q.size()); end
      for (int i = 0; i < D; i++) begin
         bus(1'b0, 4'h0, 32'h0, rd, rdy);
         exp = {24'h0, mdl_rx_read()};
         checks++; if (rd !== exp) begin failures++; $display("FAIL rx_ovf_drain%0d: got %h want %h", i, rd, exp); end
      end
   endtask

   task automatic test_rx_same_cycle();
      logic [31:0] rd;
      logic        rdy;
      logic [31:0] exp;
      logic [7:0]  nb;
      for (int i = 0; i < D; i++) rx_push(8'($urandom));
      nb = 8'($urandom);
      rx_valid = 1'b1; rx_data = nb;
      bus(1'b0, 4'h0, 32'h0, rd, rdy);
      rx_valid = 1'b0;
      exp = {24'h0, mdl_rx_read()};
      rx_q.push_back(nb);
      checks++; if (rd !== exp) begin failures++; $display("FAIL full_same_read: got %h want %h", rd, exp); end
      bus(1'b0, 4'hC, 32'h0, rd, rdy);
      checks++; if (rd !== 32'(D)) begin failures++; $display("FAIL full_same_count: got %h want %h", rd, D); end
      bus(1'b0, 4'h4, 32'h0, rd, rdy);
      checks++; if (rd !== mdl_status(0, 0)) begin failures++; $display("FAIL full_same_status: got %h want %h", rd, mdl_status(0, 0)); end
      for (int i = 0; i < D; i++) begin
         bus(1'b0, 4'h0, 32'h0, rd, rdy);
         exp = {24'h0, mdl_rx_read()};
         checks++; if (rd !== exp) begin failures++; $display("FAIL full_same_drain%0d: got %h want %h", i, rd, exp); end
      end
      nb = 8'($urandom_range(1, 255));
      rx_valid = 1'b1; rx_data = nb;
      bus(1'b0, 4'h0, 32'h0, rd, rdy);
      rx_valid = 1'b0;
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL empty_same_read: got %h want 0", rd); end
      bus(1'b0, 4'h0, 32'h0, rd, rdy);
      checks++; if (rd !== {24'h0, nb}) begin failures++; $display("FAIL empty_same_stored: got %h want %h", rd, nb); end
   endtask

   task automatic test_random_rx();
      logic [31:0] rd;
      logic        rdy;
      logic [31:0] exp;
      bit          do_rd, do_push;
      logic [7:0]  b;
      for (int i = 0; i < 60; i++) begin
         do_rd   = 1'($urandom_range(0, 1));
         do_push = 1'($urandom_range(0, 2) != 0);
         b       = 8'($urandom);
         rx_valid = do_push; rx_data = b;
         sel = do_rd; we = 1'b0; addr = 4'h0;
         step();
         rd = rdata; rdy = ready;
         sel = 1'b0; rx_valid = 1'b0;
         if (do_rd) begin
            exp = {24'h0, mdl_rx_read()};
            checks++; if (rd !== exp || rdy !== 1'b1) begin failures++; $display("FAIL rand_read%0d: got %h/%b want %h/1", i, rd, rdy, exp); end
         end
         if (do_push) begin
            if (rx_q.size() < D) rx_q.push_back(b);
            else m_rx_ovf = 1'b1;
         end
         if (i % 10 == 9) begin
            bus(1'b0, 4'h4, 32'h0, rd, rdy);
            checks++; if (rd !== mdl_status(0, 0)) begin failures++; $display("FAIL rand_status%0d: got %h want %h", i, rd, mdl_status(0, 0)); end
            bus(1'b0, 4'hC, 32'h0, rd, rdy);
            checks++; if (rd !== 32'(rx_q.size())) begin failures++; $display("FAIL rand_count%0d: got %h want %h", i, rd, rx_q.size()); end
         end
      end
      bus(1'b1, 4'h4, 32'h10, rd, rdy);
      m_rx_ovf = 1'b0;
      while (rx_q.size() != 0) begin
         bus(1'b0, 4'h0, 32'h0, rd, rdy);
         exp = {24'h0, mdl_rx_read()};
         checks++; if (rd !== exp) begin failures++; $display("FAIL rand_drain: got %h want %h", rd, exp); end
      end
   endtask

   task automatic test_tx();
      logic [31:0] rd;
      logic        rdy;
      clear_logs();
      bus(1'b1, 4'h0, 32'h55, rd, rdy);
      bus(1'b1, 4'h0, 32'hAA, rd, rdy);
      for (int i = 0; i < 200; i++) begin
         if (fall_q.size() >= 2) break;
         step();
      end
      checks++;
      if (tx_log.size() != 2 || fall_q.size() < 2) begin
         failures++; $display("FAIL tx_frames: got %0d starts %0d falls want 2/2", tx_log.size(), fall_q.size());
      end else begin
         checks++; if (tx_log[0] !== 8'h55) begin failures++; $display("FAIL tx_byte0: got %h want 55", tx_log[0]); end
         checks++; if (tx_log[1] !== 8'hAA) begin failures++; $display("FAIL tx_byte1: got %h want aa", tx_log[1]); end
         checks++; if (start_q[1] - fall_q[0] != 1) begin failures++; $display("FAIL tx_gap: got %0d want 1", start_q[1] - fall_q[0]); end
      end
      step(); step();
      bus(1'b0, 4'h4, 32'h0, rd, rdy);
      checks++; if (rd !== mdl_status(0, 0)) begin failures++; $display("FAIL tx_end_status: got %h want %h", rd, mdl_status(0, 0)); end
      checks++; if (tx_data !== 8'hAA) begin failures++; $display("FAIL tx_data_hold: got %h want aa", tx_data); end
   endtask

   // The first byte goes straight to the engine, which then stays busy long
   // enough for the FIFO to absorb D more; the byte after that is dropped.
   task automatic test_tx_overflow();
      logic [31:0] rd;
      logic        rdy;
      logic [7:0]  b[D+2];
      clear_logs();
      for (int i = 0; i < D + 2; i++) b[i] = 8'($urandom);
      for (int i = 0; i < D + 2; i++) bus(1'b1, 4'h0, {24'h0, b[i]}, rd, rdy);
      m_tx_ovf = 1'b1;
      bus(1'b0, 4'h4, 32'h0, rd, rdy);
      checks++; if (rd !== mdl_status(D, 1)) begin failures++; $display("FAIL tx_ovf_status: got %h want %h", rd, mdl_status(D, 1)); end
      bus(1'b0, 4'hC, 32'h0, rd, rdy);
      checks++; if (rd !== (32'(D) << 16)) begin failures++; $display("FAIL tx_ovf_count: got %h want %h", rd, 32'(D) << 16); end
      bus(1'b1, 4'h4, 32'h20, rd, rdy);
      m_tx_ovf = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (fall_q.size() >= D + 1) break;
         step();
      end
      step(); step(); step();
      checks++;
      if (tx_log.size() != D + 1) begin
         failures++; $display("FAIL tx_ovf_frames: got %0d want %0d", tx_log.size(), D + 1);
      end else begin
         for (int i = 0; i < D + 1; i++) begin
            checks++; if (tx_log[i] !== b[i]) begin failures++; $display("FAIL tx_ovf_byte%0d: got %h want %h", i, tx_log[i], b[i]); end
         end
      end
      bus(1'b0, 4'h4, 32'h0, rd, rdy);
      checks++; if (rd !== mdl_status(0, 0)) begin failures++; $display("FAIL tx_ovf_end_status: got %h want %h", rd, mdl_status(0, 0)); end
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      logic        rdy;
      clear_logs();
      bus(1'b1, 4'h8, 32'hFFFF_FFFF, rd, rdy);
      bus(1'b0, 4'h8, 32'h0, rd, rdy);
      checks++; if (rd !== 32'h3) begin failures++; $display("FAIL ctrl_read: got %h want 3", rd); end
      step();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx_idle: got %b want 1", irq); end
      bus(1'b1, 4'h0, 32'h5A, rd, rdy);
      step();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_drop: got %b want 0", irq); end
      for (int i = 0; i < 8; i++) step();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_mid_frame: got %b want 0", irq); end
      for (int i = 0; i < 100; i++) begin
         if (fall_q.size() >= 1) break;
         step();
      end
      step(); step();
      checks++; if (irq !== 1'b1 || fall_q.size() < 1) begin failures++; $display("FAIL irq_reassert: got %b want 1", irq); end
      bus(1'b1, 4'h8, 32'h1, rd, rdy);
      step();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_rx_only_empty: got %b want 0", irq); end
      rx_push(8'h33);
      step();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx_nonempty: got %b want 1", irq); end
      bus(1'b0, 4'h0, 32'h0, rd, rdy);
      void'(mdl_rx_read());
      step();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_rx_drained: got %b want 0", irq); end
      bus(1'b1, 4'h8, 32'h0, rd, rdy);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        rdy;
      clear_logs();
      bus(1'b1, 4'h8, 32'h1, rd, rdy);
      rx_push(8'h77);
      rx_push(8'h66);
      bus(1'b0, 4'h0, 32'h0, rd, rdy);
      void'(mdl_rx_read());
      checks++; if (rd !== 32'h77) begin failures++; $display("FAIL mid_pre_read: got %h want 77", rd); end
      bus(1'b1, 4'h0, 32'h11, rd, rdy);
      bus(1'b1, 4'h0, 32'h22, rd, rdy);
      checks++; if (tx_start !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL mid_pre_state: got start=%b irq=%b want 1/1", tx_start, irq); end
      rst = 1'b0;
      #1;
      mdl_reset();
      checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mid_rdata: got %h want 0", rdata); end
      checks++; if (tx_data !== 8'h0) begin failures++; $display("FAIL mid_tx_data: got %h want 0", tx_data); end
      checks++; if (irq !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL mid_irq_ready: got %b/%b want 0/0", irq, ready); end
      step(); step();
      rst = 1'b1;
      step();
      bus(1'b0, 4'hC, 32'h0, rd, rdy);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_count: got %h want 0", rd); end
      bus(1'b0, 4'h0, 32'h0, rd, rdy);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_rx_data: got %h want 0", rd); end
      for (int i = 0; i < 100; i++) begin
         if (fall_q.size() >= 1) break;
         step();
      end
      for (int i = 0; i < 5; i++) step();
      checks++; if (tx_log.size() != 1 || fall_q.size() != 1) begin failures++; $display("FAIL mid_discard: got %0d frames want 1", tx_log.size()); end
      bus(1'b0, 4'h4, 32'h0, rd, rdy);
      checks++; if (rd !== mdl_status(0, 0)) begin failures++; $display("FAIL mid_end_status: got %h want %h", rd, mdl_status(0, 0)); end
   endtask

   initial begin
      rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'h0;
      rx_data = 8'h0; rx_valid = 1'b0; tx_busy = 1'b0;
      eng_pend = 1'b0; eng_cnt = 0;
      mdl_reset();
      test_reset();
      test_rx_basic();
      test_rx_overflow();
      test_rx_same_cycle();
      test_random_rx();
      test_tx();
      test_tx_overflow();
      test_irq();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
